// File: rtl/bcd_pkg.sv
// Shared types and helpers for the round-robin shared binary-to-BCD converter.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } state_t;

    typedef logic [3:0] bcd_digit_t;

    // Digits needed to hold any WIDTH-bit value: ceil(width * log10(2)).
    function automatic int unsigned min_digits(input int unsigned width);
        return (width * 30103 + 99999) / 100000;
    endfunction

endpackage

// File: rtl/bcd_dabble_step.sv
// One double-dabble iteration: add-3 correction on every digit, then shift left by one.
module bcd_dabble_step
    import bcd_pkg::*;
#(
    parameter int unsigned DIGITS = 10
) (
    input  logic [4*DIGITS-1:0] bcd,
    input  logic                shift_in,
    output logic [4*DIGITS-1:0] bcd_next,
    output logic                carry_out
);

    logic [4*DIGITS-1:0] adj;

    always_comb begin
        bcd_digit_t dig;
        dig = '0;
        adj = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            dig = bcd[4*i +: 4];
            adj[4*i +: 4] = (dig >= 4'd5) ? dig + 4'd3 : dig;
        end
    end

    // Bit shifted out of the top digit is the 10^DIGITS overflow.
    assign {carry_out, bcd_next} = {adj, shift_in};

endmodule

// File: rtl/bcd_conv_sched.sv
// Round-robin scheduler sharing one iterative double-dabble converter among NREQ requesters.
module bcd_conv_sched
    import bcd_pkg::*;
#(
    parameter  int unsigned NREQ   = 4,
    parameter  int unsigned WIDTH  = 32,
    parameter  int unsigned DIGITS = 10,
    localparam int unsigned IDW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*WIDTH-1:0]   req_data,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [4*DIGITS-1:0]     rsp_bcd,
    output logic [IDW-1:0]          rsp_id,
    output logic                    rsp_ovf
);

    localparam int unsigned CW           = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam bit          OVF_POSSIBLE = DIGITS < min_digits(WIDTH);

    state_t              state;
    logic [IDW-1:0]      rr_ptr;
    logic [IDW-1:0]      id_q;
    logic [WIDTH-1:0]    shift_q;
    logic [4*DIGITS-1:0] bcd_q;
    logic [4*DIGITS-1:0] bcd_step;
    logic                carry;
    logic                ovf_q;
    logic                valid_q;
    logic [CW-1:0]       cnt;

    logic [2*NREQ-1:0]   dbl;
    logic [IDW-1:0]      off;
    logic [IDW:0]        sum;
    logic [IDW-1:0]      grant;
    logic                grant_ok;
    logic [WIDTH-1:0]    sel_data;

    // Rotate valids so rr_ptr sits at bit 0, find the first set bit, rotate the index back.
    always_comb begin
        dbl      = {req_valid, req_valid} >> rr_ptr;
        off      = '0;
        grant_ok = 1'b0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (!grant_ok && dbl[k]) begin
                grant_ok = 1'b1;
                off      = IDW'(k);
            end
        end
        sum = {1'b0, rr_ptr} + {1'b0, off};
        if (sum >= (IDW+1)'(NREQ)) begin
            sum = sum - (IDW+1)'(NREQ);
        end
        grant = sum[IDW-1:0];
    end

    always_comb begin
        sel_data = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (grant == IDW'(k)) begin
                sel_data = req_data[k*WIDTH +: WIDTH];
            end
        end
    end

    // Ready is suppressed during reset so no requester believes it was accepted.
    assign req_ready = (state == IDLE && grant_ok && !rst) ? (NREQ'(1) << grant) : '0;

    bcd_dabble_step #(
        .DIGITS(DIGITS)
    ) u_step (
        .bcd      (bcd_q),
        .shift_in (shift_q[WIDTH-1]),
        .bcd_next (bcd_step),
        .carry_out(carry)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            rr_ptr  <= '0;
            id_q    <= '0;
            shift_q <= '0;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_ok) begin
                        shift_q <= sel_data;
                        bcd_q   <= '0;
                        ovf_q   <= 1'b0;
                        cnt     <= CW'(WIDTH - 1);
                        id_q    <= grant;
                        state   <= CONV;
                    end
                end
                CONV: begin
                    shift_q <= shift_q << 1;
                    bcd_q   <= bcd_step;
                    ovf_q   <= ovf_q | carry;
                    if (cnt == '0) begin
                        state   <= DONE;
                        valid_q <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        valid_q <= 1'b0;
                        state   <= IDLE;
                        rr_ptr  <= (id_q == IDW'(NREQ - 1)) ? '0 : id_q + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign rsp_valid = valid_q;
    assign rsp_bcd   = bcd_q;
    assign rsp_id    = id_q;
    assign rsp_ovf   = OVF_POSSIBLE & ovf_q;

endmodule

// File: tb/tb_bcd_conv_sched.sv
// Self-checking bench: vector table, arithmetic reference model, round-robin scoreboard, corner sequences.
module tb_bcd_conv_sched;

    localparam int unsigned NREQ   = 4;
    localparam int unsigned WIDTH  = 32;
    localparam int unsigned DIGITS = 10;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [NREQ-1:0]       req_valid = '0;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_data = '0;
    logic                  rsp_valid;
    logic                  rsp_ready = 1'b0;
    logic [4*DIGITS-1:0]   rsp_bcd;
    logic [1:0]            rsp_id;
    logic                  rsp_ovf;

    logic        v8 = 1'b0;
    logic        rd8;
    logic [31:0] data8 = '0;
    logic        rv8;
    logic        rr8 = 1'b0;
    logic [31:0] bcd8;
    logic [0:0]  id8;
    logic        ovf8;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    bcd_conv_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_bcd(rsp_bcd), .rsp_id(rsp_id), .rsp_ovf(rsp_ovf)
    );

    bcd_conv_sched #(.NREQ(1), .WIDTH(32), .DIGITS(8)) dut8 (
        .clk(clk), .rst(rst), .req_valid(v8), .req_ready(rd8), .req_data(data8),
        .rsp_valid(rv8), .rsp_ready(rr8), .rsp_bcd(bcd8), .rsp_id(id8), .rsp_ovf(ovf8)
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog expired at time %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference: repeated division by ten, overflow when anything is left beyond nd digits.
    function automatic logic [40:0] to_bcd(input logic [31:0] v, input int unsigned nd);
        longint unsigned x;
        logic [39:0]     r;
        x = longint'(v);
        r = '0;
        for (int unsigned k = 0; k < nd; k++) begin
            r[4*k +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return {x != 0, r};
    endfunction

    logic [31:0] wbuf [NREQ][64];
    int unsigned whead [NREQ];
    int unsigned wtail [NREQ];
    int unsigned m_rr;
    int unsigned id_log[$];
    logic [39:0] last_bcd;
    logic [1:0]  last_id;
    logic        last_ovf;

    function automatic bit all_empty();
        for (int i = 0; i < NREQ; i++)
            if (whead[i] != wtail[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic push(input int unsigned r, input logic [31:0] w);
        wbuf[r][wtail[r]] = w;
        wtail[r]++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b0;
        v8        = 1'b0;
        rr8       = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            whead[i] = 0;
            wtail[i] = 0;
        end
        m_rr = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Scoreboard-driven run: requesters present queued words, model predicts grants and responses.
    task automatic run_engine(input bit rand_mode, input int unsigned budget);
        bit          busy     = 1'b0;
        bit          acc_pend = 1'b0;
        bit          hs_pend  = 1'b0;
        bit          exp_valid;
        int unsigned g   = 0;
        int unsigned lat = 0;
        int unsigned cyc = 0;
        int unsigned idx;
        logic [40:0] exp;
        logic [3:0]  exp_ready;
        exp = '0;
        while (cyc < budget && (busy || acc_pend || !all_empty())) begin
            @(negedge clk);
            cyc++;
            if (hs_pend) begin
                busy    = 1'b0;
                hs_pend = 1'b0;
                m_rr    = (g + 1) % NREQ;
            end
            if (acc_pend) begin
                exp      = to_bcd(wbuf[g][whead[g]], DIGITS);
                whead[g] = whead[g] + 1;
                busy     = 1'b1;
                lat      = 0;
                acc_pend = 1'b0;
            end else if (busy) begin
                lat++;
            end
            exp_valid = busy && (lat >= WIDTH);
            check("rsp_valid", 64'(rsp_valid), 64'(exp_valid));
            if (exp_valid) begin
                check("rsp_bcd", 64'(rsp_bcd), 64'(exp[39:0]));
                check("rsp_id", 64'(rsp_id), 64'(g));
                check("rsp_ovf", 64'(rsp_ovf), 64'(exp[40]));
            end
            rsp_ready = rand_mode ? ($urandom % 3 != 0) : 1'b1;
            if (exp_valid && rsp_ready) begin
                hs_pend  = 1'b1;
                id_log.push_back(g);
                last_bcd = rsp_bcd;
                last_id  = rsp_id;
                last_ovf = rsp_ovf;
            end
            for (int i = 0; i < NREQ; i++) begin
                if (whead[i] != wtail[i]) begin
                    req_valid[i] = rand_mode ? ($urandom % 4 != 0) : 1'b1;
                    req_data[i*WIDTH +: WIDTH] = wbuf[i][whead[i]];
                end else begin
                    req_valid[i] = 1'b0;
                    req_data[i*WIDTH +: WIDTH] = $urandom;
                end
            end
            #1;
            exp_ready = '0;
            if (!busy) begin
                for (int k = 0; k < NREQ; k++) begin
                    idx = (m_rr + k) % NREQ;
                    if (exp_ready == '0 && req_valid[idx]) begin
                        exp_ready[idx] = 1'b1;
                        g              = idx;
                        acc_pend       = 1'b1;
                    end
                end
            end
            check("req_ready", 64'(req_ready), 64'(exp_ready));
        end
        rsp_ready = 1'b0;
        req_valid = '0;
        check("engine_drain", 64'(busy || acc_pend || !all_empty()), 64'(0));
    endtask

    task automatic wait_ready(input logic [3:0] exp, input string name);
        for (int i = 0; i < 200; i++) begin
            #1;
            if (req_ready != '0) break;
            @(negedge clk);
        end
        check(name, 64'(req_ready), 64'(exp));
    endtask

    task automatic wait_rsp(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = rsp_valid;
        end
        check(name, 64'(ok), 64'(1));
    endtask

    task automatic handshake();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic run8(input logic [31:0] w);
        bit          ok = 1'b0;
        logic [40:0] exp;
        exp   = to_bcd(w, 8);
        v8    = 1'b1;
        data8 = w;
        for (int i = 0; i < 200 && !ok; i++) begin
            #1;
            ok = rd8;
            if (!ok) @(negedge clk);
        end
        check("d8_ready", 64'(ok), 64'(1));
        @(negedge clk);
        v8    = 1'b0;
        data8 = $urandom;
        ok    = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = rv8;
        end
        check("d8_rsp_valid", 64'(ok), 64'(1));
        check("d8_bcd", 64'(bcd8), 64'(exp[31:0]));
        check("d8_ovf", 64'(ovf8), 64'(exp[40]));
        check("d8_id", 64'(id8), 64'(0));
        rr8 = 1'b1;
        @(negedge clk);
        rr8 = 1'b0;
        check("d8_after_hs", 64'(rv8), 64'(0));
    endtask

    typedef struct {
        int unsigned req;
        logic [31:0] data;
        logic [39:0] bcd;
        logic        ovf;
    } vec_t;

    vec_t        vecs [6];
    logic [39:0] held;
    int unsigned bad;
    logic [31:0] w;
    int unsigned p;

    initial begin
        vecs[0] = '{0, 32'hFFFF_FFFF, 40'h42_9496_7295, 1'b0};
        vecs[1] = '{2, 32'd0,         40'h0,            1'b0};
        vecs[2] = '{2, 32'd9,         40'h9,            1'b0};
        vecs[3] = '{1, 32'd12345678,  40'h12_345678,    1'b0};
        vecs[4] = '{3, 32'd1000000000, 40'h10_0000_0000, 1'b0};
        vecs[5] = '{1, 32'd99,        40'h99,           1'b0};

        do_reset();
        #1;
        check("reset_rsp_valid", 64'(rsp_valid), 64'(0));
        check("reset_rsp_bcd", 64'(rsp_bcd), 64'(0));
        check("reset_rsp_id", 64'(rsp_id), 64'(0));
        check("reset_rsp_ovf", 64'(rsp_ovf), 64'(0));
        check("reset_req_ready", 64'(req_ready), 64'(0));

        for (int v = 0; v < 6; v++) begin
            push(vecs[v].req, vecs[v].data);
            run_engine(1'b0, 500);
            check("vec_bcd", 64'(last_bcd), 64'(vecs[v].bcd));
            check("vec_id", 64'(last_id), 64'(vecs[v].req));
            check("vec_ovf", 64'(last_ovf), 64'(vecs[v].ovf));
        end

        // All four requesters valid from reset, then 0 and 3 together after the pointer wraps.
        do_reset();
        id_log.delete();
        for (int i = 0; i < NREQ; i++) push(i, 32'(10 * (i + 1)));
        run_engine(1'b0, 1000);
        push(0, 32'd5);
        push(3, 32'd6);
        run_engine(1'b0, 1000);
        check("rr_log_len", 64'(id_log.size()), 64'(6));
        if (id_log.size() == 6) begin
            for (int i = 0; i < 4; i++) check("rr_order", 64'(id_log[i]), 64'(i));
            check("rr_wrap_first", 64'(id_log[4]), 64'(0));
            check("rr_wrap_second", 64'(id_log[5]), 64'(3));
        end

        // Response stall: outputs held, no new grant, next grant the cycle after the handshake.
        do_reset();
        req_valid = 4'b0010;
        req_data[1*WIDTH +: WIDTH] = 32'd777;
        wait_ready(4'b0010, "stall_grant");
        @(negedge clk);
        req_valid = 4'b0100;
        req_data[1*WIDTH +: WIDTH] = $urandom;
        req_data[2*WIDTH +: WIDTH] = 32'd888;
        wait_rsp("stall_rsp_valid");
        check("stall_bcd", 64'(rsp_bcd), 64'(40'h777));
        check("stall_id", 64'(rsp_id), 64'(1));
        held = rsp_bcd;
        bad  = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            if (rsp_valid !== 1'b1 || rsp_bcd !== held || rsp_id !== 2'd1 || req_ready !== 4'b0000)
                bad++;
        end
        check("stall_hold", 64'(bad), 64'(0));
        handshake();
        #1;
        check("stall_after_hs_valid", 64'(rsp_valid), 64'(0));
        check("stall_next_grant", 64'(req_ready), 64'(4'b0100));
        @(negedge clk);
        req_valid = '0;
        wait_rsp("stall_rsp2_valid");
        check("stall_bcd2", 64'(rsp_bcd), 64'(40'h888));
        check("stall_id2", 64'(rsp_id), 64'(2));
        handshake();

        // Reset in the middle of a conversion.
        do_reset();
        req_valid = 4'b1000;
        req_data[3*WIDTH +: WIDTH] = 32'd555;
        wait_ready(4'b1000, "abort_grant");
        @(negedge clk);
        req_valid = 4'b0010;
        req_data[1*WIDTH +: WIDTH] = 32'd4321;
        for (int i = 0; i < 10; i++) @(negedge clk);
        #1;
        check("abort_busy_ready", 64'(req_ready), 64'(0));
        rst = 1'b1;
        #1;
        check("abort_rsp_valid", 64'(rsp_valid), 64'(0));
        check("abort_rsp_bcd", 64'(rsp_bcd), 64'(0));
        check("abort_rsp_id", 64'(rsp_id), 64'(0));
        check("abort_req_ready", 64'(req_ready), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_regrant", 64'(req_ready), 64'(4'b0010));
        @(negedge clk);
        req_valid = '0;
        wait_rsp("abort_rsp2_valid");
        check("abort_rsp2_id", 64'(rsp_id), 64'(1));
        check("abort_rsp2_bcd", 64'(rsp_bcd), 64'(40'h4321));
        handshake();

        // Randomized traffic with stalls and withdrawn requests.
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            for (int n = 0; n < 8; n++) begin
                case ($urandom % 4)
                    0: w = $urandom;
                    1: w = $urandom % 100;
                    2: begin
                        p = 1;
                        for (int k = 0; k < int'($urandom_range(1, 9)); k++) p = p * 10;
                        w = ($urandom % 2 != 0) ? 32'(p) : 32'(p - 1);
                    end
                    default: w = ($urandom % 2 != 0) ? 32'hFFFF_FFFF : 32'd0;
                endcase
                push(i, w);
            end
        end
        run_engine(1'b1, 20000);

        // Truncating single-requester build.
        run8(32'd123456789);
        run8(32'd99999999);
        run8(32'd100000000);
        run8(32'd42);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
